// File: rtl/hsv2rgb_stream.sv
// HSV to RGB converter, 4-stage valid/ready pipeline with sideband passthrough.
// All pipeline stages advance together. A stall backs up to in_ready in the same
// cycle, so the pipeline needs no skid buffer.
module hsv2rgb_stream #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned HUE_W     = 9,
    parameter int unsigned HUE_MAX   = 360,
    parameter int unsigned SIDE_W    = 3,
    parameter bit          BGR_ORDER = 1'b0
) (
    input  logic              clk_Image_Process,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HUE_W-1:0]  HSV_Data_H,
    input  logic [DATA_W-1:0] HSV_Data_S,
    input  logic [DATA_W-1:0] HSV_Data_V,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] RGB_Data_R,
    output logic [DATA_W-1:0] RGB_Data_G,
    output logic [DATA_W-1:0] RGB_Data_B,
    output logic [SIDE_W-1:0] out_side,
    output logic [2:0]        Delay_Num,
    output logic              hue_err,
    input  logic              err_clr
);

    localparam int unsigned MAXV = (1 << DATA_W) - 1;
    localparam int unsigned SEC  = HUE_MAX / 6;
    localparam int unsigned PW   = DATA_W + HUE_W;      // S*f, S*(SEC-f), MAXV*SEC
    localparam int unsigned DW2  = 2 * DATA_W;          // V*(MAXV-C)
    localparam int unsigned NW   = 2 * DATA_W + HUE_W;  // V*(MAXV*SEC-A)

    localparam logic [HUE_W-1:0]  HUE_MAX_H = HUE_W'(HUE_MAX);
    localparam logic [HUE_W-1:0]  SEC_H     = HUE_W'(SEC);
    localparam logic [DATA_W-1:0] MAXV_D    = '1;
    localparam logic [PW-1:0]     K_P       = PW'(MAXV * SEC);

    logic adv;

    // stage 1: sector index and offset within sector
    logic [HUE_W-1:0]  hc;
    logic              s1_valid_q, s1_valid_d;
    logic [2:0]        s1_sec_q, s1_sec_d;
    logic [HUE_W-1:0]  s1_f_q, s1_f_d;
    logic [DATA_W-1:0] s1_s_q, s1_s_d, s1_v_q, s1_v_d;
    logic [SIDE_W-1:0] s1_side_q, s1_side_d;

    // stage 2: saturation products
    logic              s2_valid_q, s2_valid_d;
    logic [2:0]        s2_sec_q, s2_sec_d;
    logic [PW-1:0]     s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic [DATA_W-1:0] s2_c_q, s2_c_d, s2_v_q, s2_v_d;
    logic [SIDE_W-1:0] s2_side_q, s2_side_d;

    // stage 3: p/q/t levels
    logic [DW2-1:0]    p_full;
    logic [NW-1:0]     q_full, t_full;
    logic              s3_valid_q, s3_valid_d;
    logic [2:0]        s3_sec_q, s3_sec_d;
    logic [DATA_W-1:0] s3_p_q, s3_p_d, s3_q_q, s3_q_d, s3_t_q, s3_t_d, s3_v_q, s3_v_d;
    logic [SIDE_W-1:0] s3_side_q, s3_side_d;

    // stage 4: output register
    logic [DATA_W-1:0] sel_r, sel_g, sel_b;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [SIDE_W-1:0] out_side_q, out_side_d;

    logic              hue_err_q, hue_err_d;

    assign adv        = !out_valid_q || out_ready;
    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign RGB_Data_R = r_q;
    assign RGB_Data_G = g_q;
    assign RGB_Data_B = b_q;
    assign out_side   = out_side_q;
    assign Delay_Num  = 3'd4;
    assign hue_err    = hue_err_q;

    // stage 1: clamp out-of-range hue to 0, split into sector and offset
    always_comb begin
        hc          = (HSV_Data_H < HUE_MAX_H) ? HSV_Data_H : '0;
        s1_valid_d  = s1_valid_q;
        s1_sec_d    = s1_sec_q;
        s1_f_d      = s1_f_q;
        s1_s_d      = s1_s_q;
        s1_v_d      = s1_v_q;
        s1_side_d   = s1_side_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_sec_d   = 3'(hc / SEC_H);
            s1_f_d     = hc % SEC_H;
            s1_s_d     = HSV_Data_S;
            s1_v_d     = HSV_Data_V;
            s1_side_d  = in_side;
        end
    end

    // stage 2: full-width products S*f and S*(SEC-f)
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sec_d   = s2_sec_q;
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        s2_c_d     = s2_c_q;
        s2_v_d     = s2_v_q;
        s2_side_d  = s2_side_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_sec_d   = s1_sec_q;
            s2_a_d     = PW'(s1_s_q) * PW'(s1_f_q);
            s2_b_d     = PW'(s1_s_q) * PW'(SEC_H - s1_f_q);
            s2_c_d     = s1_s_q;
            s2_v_d     = s1_v_q;
            s2_side_d  = s1_side_q;
        end
    end

    // stage 3: exact truncating divisions by constant denominators
    always_comb begin
        p_full     = (DW2'(s2_v_q) * DW2'(MAXV_D - s2_c_q)) / DW2'(MAXV_D);
        q_full     = (NW'(s2_v_q) * NW'(K_P - s2_a_q)) / NW'(K_P);
        t_full     = (NW'(s2_v_q) * NW'(K_P - s2_b_q)) / NW'(K_P);
        s3_valid_d = s3_valid_q;
        s3_sec_d   = s3_sec_q;
        s3_p_d     = s3_p_q;
        s3_q_d     = s3_q_q;
        s3_t_d     = s3_t_q;
        s3_v_d     = s3_v_q;
        s3_side_d  = s3_side_q;
        if (adv) begin
            s3_valid_d = s2_valid_q;
            s3_sec_d   = s2_sec_q;
            s3_p_d     = DATA_W'(p_full);
            s3_q_d     = DATA_W'(q_full);
            s3_t_d     = DATA_W'(t_full);
            s3_v_d     = s2_v_q;
            s3_side_d  = s2_side_q;
        end
    end

    // stage 4: sector select and optional R/B swap
    always_comb begin
        sel_r = s3_v_q;
        sel_g = s3_p_q;
        sel_b = s3_q_q;
        case (s3_sec_q)
            3'd0:    begin sel_r = s3_v_q; sel_g = s3_t_q; sel_b = s3_p_q; end
            3'd1:    begin sel_r = s3_q_q; sel_g = s3_v_q; sel_b = s3_p_q; end
            3'd2:    begin sel_r = s3_p_q; sel_g = s3_v_q; sel_b = s3_t_q; end
            3'd3:    begin sel_r = s3_p_q; sel_g = s3_q_q; sel_b = s3_v_q; end
            3'd4:    begin sel_r = s3_t_q; sel_g = s3_p_q; sel_b = s3_v_q; end
            default: begin sel_r = s3_v_q; sel_g = s3_p_q; sel_b = s3_q_q; end
        endcase
        out_valid_d = out_valid_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        out_side_d  = out_side_q;
        if (adv) begin
            out_valid_d = s3_valid_q;
            r_d         = BGR_ORDER ? sel_b : sel_r;
            g_d         = sel_g;
            b_d         = BGR_ORDER ? sel_r : sel_b;
            out_side_d  = s3_side_q;
        end
    end

    // sticky hue error; a set in the same cycle as a clear wins
    always_comb begin
        hue_err_d = hue_err_q;
        if (err_clr)
            hue_err_d = 1'b0;
        if (in_valid && adv && (HSV_Data_H >= HUE_MAX_H))
            hue_err_d = 1'b1;
    end

    // pipeline and flag registers; reset drops all in-flight pixels
    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            s1_valid_q  <= 1'b0;
            s1_sec_q    <= '0;
            s1_f_q      <= '0;
            s1_s_q      <= '0;
            s1_v_q      <= '0;
            s1_side_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sec_q    <= '0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s2_c_q      <= '0;
            s2_v_q      <= '0;
            s2_side_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_sec_q    <= '0;
            s3_p_q      <= '0;
            s3_q_q      <= '0;
            s3_t_q      <= '0;
            s3_v_q      <= '0;
            s3_side_q   <= '0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            out_side_q  <= '0;
            hue_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sec_q    <= s1_sec_d;
            s1_f_q      <= s1_f_d;
            s1_s_q      <= s1_s_d;
            s1_v_q      <= s1_v_d;
            s1_side_q   <= s1_side_d;
            s2_valid_q  <= s2_valid_d;
            s2_sec_q    <= s2_sec_d;
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            s2_c_q      <= s2_c_d;
            s2_v_q      <= s2_v_d;
            s2_side_q   <= s2_side_d;
            s3_valid_q  <= s3_valid_d;
            s3_sec_q    <= s3_sec_d;
            s3_p_q      <= s3_p_d;
            s3_q_q      <= s3_q_d;
            s3_t_q      <= s3_t_d;
            s3_v_q      <= s3_v_d;
            s3_side_q   <= s3_side_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            out_side_q  <= out_side_d;
            hue_err_q   <= hue_err_d;
        end
    end

endmodule

// File: tb/tb_hsv2rgb_stream.sv
// Scoreboard bench for hsv2rgb_stream; a second instance built with BGR_ORDER=1
// shares the inputs and is checked against the same expected beats.
module tb_hsv2rgb_stream;

    typedef struct {
        int r;
        int g;
        int b;
        int side;
        int acc;
        bit lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [8:0] h_in;
    logic [7:0] s_in, v_in;
    logic [2:0] side_in;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready, out_valid, hue_err;
    logic [7:0] r_out, g_out, b_out;
    logic [2:0] side_out, delay_num;

    logic       bgr_in_ready, bgr_out_valid, bgr_hue_err;
    logic [7:0] bgr_r, bgr_g, bgr_b;
    logic [2:0] bgr_side, bgr_delay;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   side_cnt = 0;

    bit   prev_hold = 0;
    int   hold_r, hold_g, hold_b, hold_side;

    hsv2rgb_stream dut (
        .clk_Image_Process(clk), .Rst(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .HSV_Data_H(h_in), .HSV_Data_S(s_in), .HSV_Data_V(v_in), .in_side(side_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .RGB_Data_R(r_out), .RGB_Data_G(g_out), .RGB_Data_B(b_out), .out_side(side_out),
        .Delay_Num(delay_num), .hue_err(hue_err), .err_clr(err_clr)
    );

    hsv2rgb_stream #(.BGR_ORDER(1'b1)) dut_bgr (
        .clk_Image_Process(clk), .Rst(rst_n),
        .in_valid(in_valid), .in_ready(bgr_in_ready),
        .HSV_Data_H(h_in), .HSV_Data_S(s_in), .HSV_Data_V(v_in), .in_side(side_in),
        .out_valid(bgr_out_valid), .out_ready(out_ready),
        .RGB_Data_R(bgr_r), .RGB_Data_G(bgr_g), .RGB_Data_B(bgr_b), .out_side(bgr_side),
        .Delay_Num(bgr_delay), .hue_err(bgr_hue_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference conversion for the default 8-bit / 360-degree build.
    function automatic void model(input int h, input int s, input int v,
                                  output int r, output int g, output int b);
        int hh, sec, f, p, q, t;
        hh  = (h < 360) ? h : 0;
        sec = hh / 60;
        f   = hh - sec * 60;
        p   = (v * (255 - s)) / 255;
        q   = (v * (15300 - s * f)) / 15300;
        t   = (v * (15300 - s * (60 - f))) / 15300;
        case (sec)
            0: begin r = v; g = t; b = p; end
            1: begin r = q; g = v; b = p; end
            2: begin r = p; g = v; b = t; end
            3: begin r = p; g = q; b = v; end
            4: begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
    endfunction

    // Offer one beat; push the expected result the cycle it is accepted.
    task automatic send(input int h, input int s, input int v,
                        input int er, input int eg, input int eb, input bit lat);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        h_in     = 9'(h);
        s_in     = 8'(s);
        v_in     = 8'(v);
        side_in  = 3'(side_cnt);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 1, 0);
                break;
            end
        end
        e.r = er; e.g = eg; e.b = eb;
        e.side = side_cnt % 8;
        e.acc = cyc;
        e.lat = lat;
        exp_q.push_back(e);
        side_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input int h, input int s, input int v);
        int r, g, b;
        model(h, s, v, r, g, b);
        send(h, s, v, r, g, b, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        #1;
    endtask

    // Output monitor: scoreboard compare on transfer, stability while held.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_r", int'(r_out), hold_r);
                check("hold_g", int'(g_out), hold_g);
                check("hold_b", int'(b_out), hold_b);
                check("hold_side", int'(side_out), hold_side);
                check("hold_valid", int'(out_valid), 1);
            end
            if (out_valid && !out_ready) begin
                prev_hold = 1;
                hold_r = int'(r_out);
                hold_g = int'(g_out);
                hold_b = int'(b_out);
                hold_side = int'(side_out);
                check("in_ready_stall", int'(in_ready), 0);
            end else begin
                prev_hold = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("r", int'(r_out), e.r);
                    check("g", int'(g_out), e.g);
                    check("b", int'(b_out), e.b);
                    check("side", int'(side_out), e.side);
                    check("bgr_valid", int'(bgr_out_valid), 1);
                    check("bgr_r", int'(bgr_r), e.b);
                    check("bgr_g", int'(bgr_g), e.g);
                    check("bgr_b", int'(bgr_b), e.r);
                    if (e.lat) check("latency", cyc - e.acc, 4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        h_in = '0; s_in = '0; v_in = '0; side_in = '0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_out_valid", int'(out_valid), 0);
        check("rst_r", int'(r_out), 0);
        check("rst_g", int'(g_out), 0);
        check("rst_b", int'(b_out), 0);
        check("rst_side", int'(side_out), 0);
        check("rst_hue_err", int'(hue_err), 0);
        check("delay_num", int'(delay_num), 4);
        check("in_ready_idle", int'(in_ready), 1);

        // primaries, back-to-back
        send(0,   255, 255, 255, 0,   0,   1'b1);
        send(60,  255, 255, 255, 255, 0,   1'b1);
        send(120, 255, 255, 0,   255, 0,   1'b1);
        send(180, 255, 255, 0,   255, 255, 1'b1);
        send(240, 255, 255, 0,   0,   255, 1'b1);
        send(300, 255, 255, 255, 0,   255, 1'b1);
        // fractional hue and grey / black
        send(30,  255, 255, 255, 127, 0,   1'b1);
        send(0,   0,   200, 200, 200, 200, 1'b1);
        send(0,   0,   0,   0,   0,   0,   1'b1);
        drain();
        check("hue_err_clean", int'(hue_err), 0);

        // backpressure: 8 back-to-back pixels, out_ready low for 3 cycles
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send_m(int'($urandom_range(0, 359)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // out-of-range hue and sticky flag
        send(400, 255, 255, 255, 0, 0, 1'b1);
        check("hue_err_set", int'(hue_err), 1);
        repeat (3) @(posedge clk);
        #1;
        check("hue_err_sticky", int'(hue_err), 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("hue_err_clr", int'(hue_err), 0);
        err_clr = 1'b1;
        send(400, 255, 255, 255, 0, 0, 1'b1);
        err_clr = 1'b0;
        check("hue_err_set_wins", int'(hue_err), 1);
        drain();

        // reset with the output held and 3 pixels behind it
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send_m(int'($urandom_range(0, 359)), 255, 255);
        check("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_r", int'(r_out), 0);
        check("mid_rst_g", int'(g_out), 0);
        check("mid_rst_b", int'(b_out), 0);
        check("mid_rst_side", int'(side_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(120, 255, 255, 0, 255, 0, 1'b1);
        drain();

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
